// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing the data memory between CPU and debug port.
// Define DMEM_ARB_PERF_EN to add per-requester saturating wait-cycle counters.
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic              dbg_lock,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
`ifdef DMEM_ARB_PERF_EN
    output logic [31:0]       cpu_wait_cnt,
    output logic [31:0]       dbg_wait_cnt,
`endif
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {
        S_IDLE,
        S_DBG_LOCK
    } state_t;

    typedef enum logic {
        OWN_CPU,
        OWN_DBG
    } owner_t;

    localparam logic [7:0] MAX_H = 8'(MAX_HOLD);

    state_t            state_q, state_d;
    owner_t            last_q, last_d;
    logic [7:0]        hold_q, hold_d;
    logic              cpu_rvalid_q, cpu_rvalid_d;
    logic              dbg_rvalid_q, dbg_rvalid_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_q       <= OWN_DBG;
            hold_q       <= '0;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            hold_q       <= hold_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        hold_d  = hold_q;
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (!reset) begin
            unique case (state_q)
                S_IDLE: begin
                    if (cpu_req && dbg_req) begin
                        cpu_gnt = (last_q == OWN_DBG);
                        dbg_gnt = (last_q == OWN_CPU);
                    end else begin
                        cpu_gnt = cpu_req;
                        dbg_gnt = dbg_req;
                    end
                    if (cpu_gnt) begin
                        last_d = OWN_CPU;
                    end
                    // A one-access hold limit degenerates to unlocked arbitration.
                    if (dbg_gnt) begin
                        last_d = OWN_DBG;
                        if (dbg_lock && (MAX_H > 8'd1)) begin
                            state_d = S_DBG_LOCK;
                            hold_d  = 8'd1;
                        end
                    end
                end
                S_DBG_LOCK: begin
                    dbg_gnt = dbg_req && dbg_lock && (hold_q < MAX_H);
                    hold_d  = hold_q + {7'd0, dbg_gnt};
                    if (!dbg_req || !dbg_lock || (hold_d == MAX_H)) begin
                        state_d = S_IDLE;
                        hold_d  = '0;
                        last_d  = OWN_DBG;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    hold_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        mem_en    = cpu_gnt | dbg_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dbg_gnt) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    // Returned data passes straight through in the rvalid cycle, then is held.
    always_comb begin
        cpu_rvalid   = cpu_rvalid_q & ~reset;
        dbg_rvalid   = dbg_rvalid_q & ~reset;
        cpu_rvalid_d = cpu_gnt & ~cpu_we;
        dbg_rvalid_d = dbg_gnt & ~dbg_we;
        cpu_rdata_d  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
        dbg_rdata_d  = dbg_rvalid ? mem_rdata : dbg_rdata_q;
        cpu_rdata    = cpu_rdata_d;
        dbg_rdata    = dbg_rdata_d;
    end

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] cpu_wait_q, cpu_wait_d;
    logic [31:0] dbg_wait_q, dbg_wait_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_wait_q <= '0;
            dbg_wait_q <= '0;
        end else begin
            cpu_wait_q <= cpu_wait_d;
            dbg_wait_q <= dbg_wait_d;
        end
    end

    always_comb begin
        cpu_wait_d = cpu_wait_q;
        dbg_wait_d = dbg_wait_q;
        if (cpu_req && !cpu_gnt && (cpu_wait_q != 32'hFFFF_FFFF)) begin
            cpu_wait_d = cpu_wait_q + 32'd1;
        end
        if (dbg_req && !dbg_gnt && (dbg_wait_q != 32'hFFFF_FFFF)) begin
            dbg_wait_d = dbg_wait_q + 32'd1;
        end
    end

    assign cpu_wait_cnt = cpu_wait_q;
    assign dbg_wait_cnt = dbg_wait_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus with a cycle-level arbitration model and literal checks.
// Build with DMEM_ARB_PERF_EN to also check the wait-cycle counters.
module tb_dmem_arbiter;

    localparam int MAXH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
    logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
    logic [31:0] cpu_rdata, dbg_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0] cpu_wait_cnt, dbg_wait_cnt;
`endif

    int errors = 0;
    int checks = 0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(MAXH)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt),
        .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
`ifdef DMEM_ARB_PERF_EN
        .cpu_wait_cnt(cpu_wait_cnt), .dbg_wait_cnt(dbg_wait_cnt),
`endif
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory
    logic [31:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem_rdata = '0;
    end
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
            else mem_rdata <= mem[mem_addr[9:2]];
        end
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: whose turn it is on a tie, length of the current
    // locked burst, a shadow of memory contents and the read-return pipeline.
    logic [31:0] shadow [256];
    int          burst;
    bit          cpu_turn;
    bit          pend_c, pend_d;
    logic [31:0] pdat_c, pdat_d, hold_c, hold_d;
    longint      wait_c, wait_d;
    initial begin
        for (int i = 0; i < 256; i++) shadow[i] = '0;
        burst = 0; cpu_turn = 1; pend_c = 0; pend_d = 0;
        pdat_c = '0; pdat_d = '0; hold_c = '0; hold_d = '0;
        wait_c = 0; wait_d = 0;
    end

    always @(negedge clk) begin
        bit          eg_c, eg_d, rv_c, rv_d, e_we;
        logic [31:0] e_addr, e_wdata;
        if (reset) begin
            eg_c = 0; eg_d = 0;
        end else if (burst > 0) begin
            eg_c = 0; eg_d = dbg_req && dbg_lock;
        end else if (cpu_req && dbg_req) begin
            eg_c = cpu_turn; eg_d = !cpu_turn;
        end else begin
            eg_c = cpu_req; eg_d = dbg_req;
        end
        e_we = 0; e_addr = '0; e_wdata = '0;
        if (eg_c) begin
            e_we = cpu_we; e_addr = cpu_addr; e_wdata = cpu_wdata;
        end else if (eg_d) begin
            e_we = dbg_we; e_addr = dbg_addr; e_wdata = dbg_wdata;
        end
        rv_c = pend_c && !reset;
        rv_d = pend_d && !reset;
        check("m_cpu_gnt", cpu_gnt, eg_c);
        check("m_dbg_gnt", dbg_gnt, eg_d);
        check("m_mem_en", mem_en, eg_c || eg_d);
        check("m_mem_we", mem_we, e_we);
        check("m_mem_addr", mem_addr, e_addr);
        check("m_mem_wdata", mem_wdata, e_wdata);
        check("m_cpu_rvalid", cpu_rvalid, rv_c);
        check("m_dbg_rvalid", dbg_rvalid, rv_d);
        check("m_cpu_rdata", cpu_rdata, rv_c ? pdat_c : hold_c);
        check("m_dbg_rdata", dbg_rdata, rv_d ? pdat_d : hold_d);
`ifdef DMEM_ARB_PERF_EN
        check("m_cpu_wait", cpu_wait_cnt, wait_c);
        check("m_dbg_wait", dbg_wait_cnt, wait_d);
`endif
        if (rv_c) hold_c = pdat_c;
        if (rv_d) hold_d = pdat_d;
        if (reset) begin
            burst = 0; cpu_turn = 1; pend_c = 0; pend_d = 0;
            hold_c = '0; hold_d = '0; wait_c = 0; wait_d = 0;
        end else begin
            if (cpu_req && !eg_c && wait_c < 64'hFFFF_FFFF) wait_c++;
            if (dbg_req && !eg_d && wait_d < 64'hFFFF_FFFF) wait_d++;
            pend_c = eg_c && !cpu_we;
            pend_d = eg_d && !dbg_we;
            if (pend_c) pdat_c = shadow[cpu_addr[9:2]];
            if (pend_d) pdat_d = shadow[dbg_addr[9:2]];
            if (eg_c && cpu_we) shadow[cpu_addr[9:2]] = cpu_wdata;
            if (eg_d && dbg_we) shadow[dbg_addr[9:2]] = dbg_wdata;
            if (eg_c) cpu_turn = 0;
            if (eg_d) cpu_turn = 1;
            if (burst > 0) begin
                if (eg_d) burst++;
                if (!eg_d || burst == MAXH) begin
                    burst = 0; cpu_turn = 1;
                end
            end else if (eg_d && dbg_lock && MAXH > 1) begin
                burst = 1;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_cpu(input logic r, input logic w,
                           input logic [31:0] a, input logic [31:0] d);
        cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_dbg(input logic r, input logic w, input logic l,
                           input logic [31:0] a, input logic [31:0] d);
        dbg_req = r; dbg_we = w; dbg_lock = l; dbg_addr = a; dbg_wdata = d;
    endtask

    task automatic idle();
        set_cpu(0, 0, '0, '0);
        set_dbg(0, 0, 0, '0, '0);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        set_cpu(1, 0, 32'h10, '0);
        set_dbg(1, 0, 0, 32'h20, '0);
        cyc();
        settle();
        check("rst_cpu_gnt", cpu_gnt, 0);
        check("rst_dbg_gnt", dbg_gnt, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_cpu_rvalid", cpu_rvalid, 0);
        cyc();
        reset = 1'b0;
        idle();

        // CPU write then read back
        set_cpu(1, 1, 32'h64, 32'h7);
        settle();
        check("wr_cpu_gnt", cpu_gnt, 1);
        check("wr_mem_we", mem_we, 1);
        check("wr_dbg_gnt", dbg_gnt, 0);
        cyc();
        set_cpu(1, 0, 32'h64, '0);
        settle();
        check("rd_cpu_gnt", cpu_gnt, 1);
        check("rd_mem_we", mem_we, 0);
        cyc();
        idle();
        settle();
        check("rd_rvalid", cpu_rvalid, 1);
        check("rd_rdata", cpu_rdata, 32'h7);
        cyc();
        settle();
        check("rd_rvalid_drop", cpu_rvalid, 0);
        check("rd_rdata_hold", cpu_rdata, 32'h7);

        // Unlocked tie after reset alternates CPU first
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        set_cpu(1, 0, 32'h10, '0);
        set_dbg(1, 0, 0, 32'h20, '0);
        for (int i = 0; i < 4; i++) begin
            settle();
            check("rr_cpu_gnt", cpu_gnt, (i % 2) == 0);
            check("rr_dbg_gnt", dbg_gnt, (i % 2) == 1);
            check("rr_mem_addr", mem_addr, (i % 2) ? 32'h20 : 32'h10);
            cyc();
        end
        idle();
        cyc();

        // Locked burst of MAX_HOLD, then the waiting CPU
        set_cpu(1, 0, 32'h10, '0);
        cyc();
        set_dbg(1, 1, 1, 32'h24, 32'h55);
        for (int i = 0; i < 5; i++) begin
            settle();
            check("lk_dbg_gnt", dbg_gnt, i < 4);
            check("lk_cpu_gnt", cpu_gnt, i == 4);
            cyc();
        end
        idle();
        cyc();

        // Lock dropped early, then a fresh full burst
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        set_cpu(1, 0, 32'h30, '0);
        cyc();
        set_dbg(1, 0, 1, 32'h40, '0);
        for (int i = 0; i < 2; i++) begin
            settle();
            check("ed_dbg_gnt", dbg_gnt, 1);
            check("ed_cpu_gnt", cpu_gnt, 0);
            cyc();
        end
        set_dbg(0, 0, 0, '0, '0);
        settle();
        check("ed_exit_cpu_gnt", cpu_gnt, 0);
        cyc();
        settle();
        check("ed_cpu_gnt_after", cpu_gnt, 1);
`ifdef DMEM_ARB_PERF_EN
        check("perf_cpu_wait", cpu_wait_cnt, 3);
        check("perf_dbg_wait", dbg_wait_cnt, 0);
`endif
        cyc();
        set_cpu(0, 0, '0, '0);
        set_dbg(1, 0, 1, 32'h44, '0);
        for (int i = 0; i < 4; i++) begin
            settle();
            check("nb_dbg_gnt", dbg_gnt, 1);
            cyc();
        end
        set_cpu(1, 0, 32'h30, '0);
        settle();
        check("nb_cpu_gnt", cpu_gnt, 1);
        check("nb_dbg_gnt_end", dbg_gnt, 0);
        cyc();
        idle();
        cyc();

        // Reset right after a granted debug read
        set_dbg(1, 0, 0, 32'h64, '0);
        settle();
        check("rr_dbg_rd_gnt", dbg_gnt, 1);
        cyc();
        reset = 1'b1;
        set_cpu(1, 0, 32'h10, '0);
        set_dbg(1, 0, 0, 32'h20, '0);
        settle();
        check("rm_dbg_rvalid", dbg_rvalid, 0);
        check("rm_dbg_gnt", dbg_gnt, 0);
        check("rm_cpu_gnt", cpu_gnt, 0);
        check("rm_mem_en", mem_en, 0);
        cyc();
        reset = 1'b0;
        settle();
        check("rm_post_rvalid", dbg_rvalid, 0);
        check("rm_post_cpu_gnt", cpu_gnt, 1);
        check("rm_post_dbg_gnt", dbg_gnt, 0);
        cyc();
        idle();
        cyc();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
